serial_adder: RTL and testbench
===============================

// Module: serial_adder
// PURPOSE
//  Multi-cycle, parametrised adder/subtractor. Each cycle it processes a DIGIT-bit slice,
//  LSB first, through a full-adder chain and a registered carry.
//  Sits between a producer and a consumer on valid/ready handshakes.
//  Trades latency for area on wide operands. Adds subtract mode and signed-overflow detection.
// PARAMETERS
//  WIDTH  8  operand/result width in bits; must be >= 2
//  DIGIT  1  bits processed per cycle; WIDTH % DIGIT must be 0
//  (STEPS = WIDTH/DIGIT is derived, not a parameter)
// PORTS
//  clk        in   1      single clock; all state updates on rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      operands a, b, cin, sub are valid
//  in_ready   out  1      block can accept a new operation
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry-in (add mode only)
//  sub        in   1      0: a+b+cin; 1: a-b (cin ignored)
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result
//  sum        out  WIDTH  result, modulo 2^WIDTH
//  cout       out  1      carry out of MSB; in sub mode 1 = no borrow
//  overflow   out  1      two's-complement overflow (carry into MSB XOR carry out of MSB)
// BEHAVIOUR
//  Reset (rst_n low, async):
//   - state=IDLE; out_valid, sum, cout, overflow = 0; internal counter and carry = 0.
//   - in_ready=1 from reset release.
//   - Reset mid-operation aborts: no result is produced and no out_valid pulse follows.
//  FSM IDLE -> RUN -> DONE -> IDLE:
//   - IDLE: in_ready=1. On in_valid&in_ready at edge k:
//     - latch a and b (b inverted when sub=1);
//     - carry = sub ? 1 : cin; count = 0; go to RUN.
//   - RUN: in_ready=0, out_valid=0. Each edge adds one DIGIT slice [count*DIGIT +: DIGIT]
//     with the carry reg, writes the slice result into sum, updates carry, count++.
//     - After edge k+STEPS (count reached STEPS), go to DONE.
//     - On the last step, capture overflow = carry into bit WIDTH-1 XOR carry out of it;
//       cout = final carry.
//   - DONE: out_valid=1; sum/cout/overflow are held stable. in_ready=0.
//     On out_valid&out_ready go to IDLE at that edge.
//  Latency/throughput:
//   - out_valid rises after edge k+STEPS (STEPS+1 cycles after the accept edge).
//   - Minimum period between accepts is STEPS+2 cycles.
//  Handshake rules:
//   - in_valid is ignored when in_ready=0, and inputs may change freely then.
//   - out_ready is ignored outside DONE.
//   - Outputs are unspecified-but-stable only in DONE; sum/cout/overflow may change during RUN.
//   - Unbounded backpressure in DONE is legal; the result is held indefinitely.
//  Boundary conditions:
//   - DIGIT=WIDTH is legal (STEPS=1). The overflow calculation then uses the internal
//     carry at bit WIDTH-1.
//   - WIDTH%DIGIT!=0 or WIDTH<2: elaboration-time error ($error in generate block).
//   - sub with a==b: sum=0, cout=1, overflow=0.
// TESTING
//  1. W8/D1, add FF+01, cin=0 -> sum=00, cout=1, ovf=0; out_valid exactly 9 cycles after accept.
//  2. W8/D1, add 7F+01 -> sum=80, cout=0, ovf=1; sub 05-07 -> sum=FE, cout=0, ovf=0.
//  3. W8/D4, add 3C+4D, cin=1 -> sum=8A, cout=0, ovf=1; out_valid 3 cycles after accept.
//  4. Backpressure: hold out_ready=0 for 5 cycles in DONE, with in_valid=1 and new operands
//     -> result stable, in_ready=0, new op accepted only after return to IDLE.
//  5. Reset pulse at RUN count=3 -> out_valid never rises; in_ready=1 after release;
//     next op (10+20) -> sum=30.
//  6. Random add/sub, 1000 ops, W16/D2 and W8/D8 (both sub values) with random valid/ready
//     gaps -> compare against a reference model. The reference model checks sum, cout,
//     overflow and the latency of every result.

Source files
------------

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: one DIGIT-bit slice per cycle, LSB first, through a
// registered carry, with valid/ready handshakes on both sides and signed-overflow output.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  generate
    if (WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("serial_adder: WIDTH must be >= 2 and a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [CW-1:0]    count_q, count_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [DIGIT-1:0] a_sl, b_sl, s_sl;
  logic             c, c_top;

  // Ripple through the current slice; c_top ends as the carry into the slice MSB,
  // which on the final step is the carry into bit WIDTH-1.
  always_comb begin
    a_sl  = a_q[int'(count_q) * DIGIT +: DIGIT];
    b_sl  = b_q[int'(count_q) * DIGIT +: DIGIT];
    s_sl  = '0;
    c     = carry_q;
    c_top = carry_q;
    for (int unsigned i = 0; i < DIGIT; i++) begin
      c_top   = c;
      s_sl[i] = a_sl[i] ^ b_sl[i] ^ c;
      c       = (a_sl[i] & b_sl[i]) | (c & (a_sl[i] ^ b_sl[i]));
    end
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    count_d     = count_q;
    carry_d     = carry_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d        = a;
          b_d        = sub ? ~b : b;
          carry_d    = sub ? 1'b1 : cin;
          count_d    = '0;
          in_ready_d = 1'b0;
          state_d    = RUN;
        end
      end
      RUN: begin
        sum_d[int'(count_q) * DIGIT +: DIGIT] = s_sl;
        carry_d = c;
        count_d = count_q + CW'(1);
        if (count_q == CW'(STEPS - 1)) begin
          cout_d      = c;
          ovf_d       = c_top ^ c;
          count_d     = '0;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      count_q     <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      count_q     <= count_d;
      carry_q     <= carry_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and randomised checks of serial_adder at four WIDTH/DIGIT configurations
// sharing one clock and reset: 8/1, 8/4, 16/2 and 8/8.
module tb_serial_adder;

  logic        clk;
  logic        rst_n;
  logic [3:0]  iv, ordy, irdy, ovld, cin_s, sub_s, cout_s, ovf_s;
  logic [15:0] a_s [4];
  logic [15:0] b_s [4];
  logic [15:0] sum_s [4];
  logic [7:0]  sum0, sum1, sum3;
  logic [15:0] sum2;

  int n_cmp  = 0;
  int n_fail = 0;

  assign sum_s[0] = {8'h00, sum0};
  assign sum_s[1] = {8'h00, sum1};
  assign sum_s[2] = sum2;
  assign sum_s[3] = {8'h00, sum3};

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_w8d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(irdy[0]),
    .a(a_s[0][7:0]), .b(b_s[0][7:0]), .cin(cin_s[0]), .sub(sub_s[0]),
    .out_valid(ovld[0]), .out_ready(ordy[0]), .sum(sum0), .cout(cout_s[0]), .overflow(ovf_s[0]));

  serial_adder #(.WIDTH(8), .DIGIT(4)) u_w8d4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(irdy[1]),
    .a(a_s[1][7:0]), .b(b_s[1][7:0]), .cin(cin_s[1]), .sub(sub_s[1]),
    .out_valid(ovld[1]), .out_ready(ordy[1]), .sum(sum1), .cout(cout_s[1]), .overflow(ovf_s[1]));

  serial_adder #(.WIDTH(16), .DIGIT(2)) u_w16d2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(irdy[2]),
    .a(a_s[2]), .b(b_s[2]), .cin(cin_s[2]), .sub(sub_s[2]),
    .out_valid(ovld[2]), .out_ready(ordy[2]), .sum(sum2), .cout(cout_s[2]), .overflow(ovf_s[2]));

  serial_adder #(.WIDTH(8), .DIGIT(8)) u_w8d8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(irdy[3]),
    .a(a_s[3][7:0]), .b(b_s[3][7:0]), .cin(cin_s[3]), .sub(sub_s[3]),
    .out_valid(ovld[3]), .out_ready(ordy[3]), .sum(sum3), .cout(cout_s[3]), .overflow(ovf_s[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int steps_of(input int id);
    case (id)
      0: return 8;
      1: return 2;
      2: return 8;
      default: return 1;
    endcase
  endfunction

  // Reference: whole-word arithmetic, overflow from operand/result signs.
  function automatic void model(input int w, input logic [15:0] aa, input logic [15:0] bb,
                                input logic ci, input logic sb,
                                output logic [15:0] s, output logic co, output logic ov);
    logic [16:0] t;
    logic [15:0] mask, am, bx;
    mask = (w == 16) ? 16'hFFFF : 16'h00FF;
    am   = aa & mask;
    bx   = (sb ? ~bb : bb) & mask;
    t    = {1'b0, am} + {1'b0, bx} + (sb ? 17'd1 : {16'd0, ci});
    s    = t[15:0] & mask;
    co   = t[w];
    ov   = (am[w-1] == bx[w-1]) && (s[w-1] != am[w-1]);
  endfunction

  task automatic start_op(input int id, input logic [15:0] aa, input logic [15:0] bb,
                          input logic ci, input logic sb);
    int g;
    g = 0;
    a_s[id] = aa; b_s[id] = bb; cin_s[id] = ci; sub_s[id] = sb; iv[id] = 1'b1;
    while (!irdy[id] && g < 100) begin
      @(posedge clk); #1; g++;
    end
    if (g >= 100) begin
      n_cmp++; n_fail++;
      $display("FAIL accept_timeout id=%0d: in_ready=%b required 1", id, irdy[id]);
    end
    @(posedge clk); #1;
    iv[id] = 1'b0;
  endtask

  // Edges after the accept edge until out_valid is seen high.
  task automatic wait_valid(input int id, output int lat);
    lat = 0;
    while (!ovld[id] && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic finish_op(input int id);
    ordy[id] = 1'b1;
    @(posedge clk); #1;
    ordy[id] = 1'b0;
  endtask

  task automatic test_reset();
    iv = '0; ordy = '0; cin_s = '0; sub_s = '0;
    for (int i = 0; i < 4; i++) begin a_s[i] = '0; b_s[i] = '0; end
    rst_n = 1'b0;
    #22 rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (irdy !== 4'b1111) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1111", irdy); end
    n_cmp++; if (ovld !== 4'b0000) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0000", ovld); end
    n_cmp++; if (sum_s[2] !== 16'h0000) begin n_fail++; $display("FAIL reset_sum: got %h want 0000", sum_s[2]); end
    n_cmp++; if ({cout_s, ovf_s} !== 8'h00) begin n_fail++; $display("FAIL reset_cout_ovf: got %h want 00", {cout_s, ovf_s}); end
  endtask

  task automatic test_add_carry_d1();
    int lat;
    start_op(0, 16'hFF, 16'h01, 1'b0, 1'b0);
    n_cmp++; if (irdy[0] !== 1'b0) begin n_fail++; $display("FAIL busy_in_ready: got %b want 0", irdy[0]); end
    wait_valid(0, lat);
    n_cmp++; if (lat !== 8) begin n_fail++; $display("FAIL d1_latency: got %0d edges want 8", lat); end
    n_cmp++; if (sum_s[0] !== 16'h00) begin n_fail++; $display("FAIL d1_ff01_sum: got %h want 00", sum_s[0]); end
    n_cmp++; if (cout_s[0] !== 1'b1) begin n_fail++; $display("FAIL d1_ff01_cout: got %b want 1", cout_s[0]); end
    n_cmp++; if (ovf_s[0] !== 1'b0) begin n_fail++; $display("FAIL d1_ff01_ovf: got %b want 0", ovf_s[0]); end
    finish_op(0);
    n_cmp++; if ({ovld[0], irdy[0]} !== 2'b01) begin n_fail++; $display("FAIL d1_release: got v/r=%b want 01", {ovld[0], irdy[0]}); end
  endtask

  task automatic test_ovf_sub_d1();
    int lat;
    start_op(0, 16'h7F, 16'h01, 1'b0, 1'b0);
    wait_valid(0, lat);
    n_cmp++; if ({sum_s[0][7:0], cout_s[0], ovf_s[0]} !== {8'h80, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL d1_7f01: got sum=%h c=%b v=%b want 80 0 1", sum_s[0][7:0], cout_s[0], ovf_s[0]); end
    finish_op(0);
    start_op(0, 16'h05, 16'h07, 1'b1, 1'b1);
    wait_valid(0, lat);
    n_cmp++; if ({sum_s[0][7:0], cout_s[0], ovf_s[0]} !== {8'hFE, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL d1_sub0507: got sum=%h c=%b v=%b want fe 0 0", sum_s[0][7:0], cout_s[0], ovf_s[0]); end
    finish_op(0);
  endtask

  task automatic test_digit4();
    int lat;
    start_op(1, 16'h3C, 16'h4D, 1'b1, 1'b0);
    wait_valid(1, lat);
    n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL d4_latency: got %0d edges want 2", lat); end
    n_cmp++; if ({sum_s[1][7:0], cout_s[1], ovf_s[1]} !== {8'h8A, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL d4_3c4d: got sum=%h c=%b v=%b want 8a 0 1", sum_s[1][7:0], cout_s[1], ovf_s[1]); end
    finish_op(1);
  endtask

  task automatic test_full_digit();
    int lat;
    start_op(3, 16'h7F, 16'h01, 1'b0, 1'b0);
    wait_valid(3, lat);
    n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL d8_latency: got %0d edges want 1", lat); end
    n_cmp++; if ({sum_s[3][7:0], cout_s[3], ovf_s[3]} !== {8'h80, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL d8_7f01: got sum=%h c=%b v=%b want 80 0 1", sum_s[3][7:0], cout_s[3], ovf_s[3]); end
    finish_op(3);
    start_op(3, 16'h5A, 16'h5A, 1'b0, 1'b1);
    wait_valid(3, lat);
    n_cmp++; if ({sum_s[3][7:0], cout_s[3], ovf_s[3]} !== {8'h00, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL d8_sub_equal: got sum=%h c=%b v=%b want 00 1 0", sum_s[3][7:0], cout_s[3], ovf_s[3]); end
    finish_op(3);
  endtask

  task automatic test_back_to_back();
    int lat;
    start_op(0, 16'h0F, 16'h01, 1'b0, 1'b0);
    wait_valid(0, lat);
    a_s[0] = 16'h01; b_s[0] = 16'h01; cin_s[0] = 1'b0; sub_s[0] = 1'b0; iv[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_cmp++; if ({ovld[0], irdy[0], sum_s[0][7:0]} !== {1'b1, 1'b0, 8'h10}) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got v=%b r=%b sum=%h want 1 0 10", i, ovld[0], irdy[0], sum_s[0][7:0]); end
    end
    finish_op(0);
    n_cmp++; if ({ovld[0], irdy[0]} !== 2'b01) begin n_fail++; $display("FAIL bp_idle: got v/r=%b want 01", {ovld[0], irdy[0]}); end
    @(posedge clk); #1;
    iv[0] = 1'b0;
    n_cmp++; if (irdy[0] !== 1'b0) begin n_fail++; $display("FAIL bp_accept: got in_ready=%b want 0", irdy[0]); end
    wait_valid(0, lat);
    n_cmp++; if ({lat[7:0], sum_s[0][7:0]} !== {8'd8, 8'h02}) begin
      n_fail++; $display("FAIL bp_next: got lat=%0d sum=%h want 8 02", lat, sum_s[0][7:0]); end
    finish_op(0);
  endtask

  task automatic test_reset_mid_run();
    int lat;
    int seen;
    start_op(0, 16'hAA, 16'h55, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #3 rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (ovld[0]) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_fail++; $display("FAIL abort_no_valid: got %0d valid cycles want 0", seen); end
    n_cmp++; if (irdy[0] !== 1'b1) begin n_fail++; $display("FAIL abort_in_ready: got %b want 1", irdy[0]); end
    start_op(0, 16'h10, 16'h20, 1'b0, 1'b0);
    wait_valid(0, lat);
    n_cmp++; if ({sum_s[0][7:0], cout_s[0], ovf_s[0]} !== {8'h30, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL abort_next: got sum=%h c=%b v=%b want 30 0 0", sum_s[0][7:0], cout_s[0], ovf_s[0]); end
    finish_op(0);
  endtask

  task automatic test_random();
    logic [15:0] es [4];
    logic        ec [4];
    logic        eo [4];
    bit          pend [4];
    bit          shake [4];
    int          acc [4];
    int          ops [4];
    int          st;
    for (int i = 0; i < 4; i++) begin
      es[i] = '0; ec[i] = 1'b0; eo[i] = 1'b0; pend[i] = 0; shake[i] = 0; acc[i] = 0; ops[i] = 0;
    end
    for (int cyc = 0; cyc < 60000 && (ops[2] < 500 || ops[3] < 500); cyc++) begin
      for (int id = 2; id < 4; id++) begin
        iv[id]    = ($urandom_range(0, 3) != 0);
        ordy[id]  = ($urandom_range(0, 2) != 0);
        a_s[id]   = 16'($urandom);
        b_s[id]   = 16'($urandom);
        cin_s[id] = 1'($urandom);
        sub_s[id] = 1'($urandom);
        shake[id] = ovld[id] && ordy[id];
        if (iv[id] && irdy[id]) begin
          model((id == 2) ? 16 : 8, a_s[id], b_s[id], cin_s[id], sub_s[id], es[id], ec[id], eo[id]);
          pend[id] = 1; acc[id] = cyc;
        end
      end
      @(posedge clk); #1;
      for (int id = 2; id < 4; id++) begin
        st = steps_of(id);
        if (shake[id]) begin pend[id] = 0; ops[id]++; end
        n_cmp++;
        if (ovld[id] !== (pend[id] && (cyc - acc[id]) >= st)) begin
          n_fail++; $display("FAIL rand_valid id=%0d cyc=%0d: got %b want %b", id, cyc, ovld[id], pend[id] && (cyc - acc[id]) >= st);
        end
        if (pend[id] && (cyc - acc[id]) >= st) begin
          n_cmp++;
          if ({sum_s[id], cout_s[id], ovf_s[id]} !== {es[id], ec[id], eo[id]}) begin
            n_fail++; $display("FAIL rand_result id=%0d cyc=%0d: got sum=%h c=%b v=%b want %h %b %b",
                               id, cyc, sum_s[id], cout_s[id], ovf_s[id], es[id], ec[id], eo[id]);
          end
        end
      end
    end
    iv = '0; ordy = '0;
    n_cmp++; if (ops[2] < 500 || ops[3] < 500) begin
      n_fail++; $display("FAIL rand_ops: got %0d/%0d want 500/500", ops[2], ops[3]); end
  endtask

  initial begin
    test_reset();
    test_add_carry_d1();
    test_ovf_sub_d1();
    test_digit4();
    test_full_digit();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
